// File: rtl/seq_unsigned_divider_if.sv
// rtl/seq_unsigned_divider_if.sv - operand/result bundle between the I/O wrapper and the divider
interface seq_unsigned_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_unsigned_divider.sv
// rtl/seq_unsigned_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Optional DIV_SHORTCUT_EN: finish divisor==0 / dividend<divisor in a single cycle.
module seq_unsigned_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_unsigned_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             shortcut;

`ifdef DIV_SHORTCUT_EN
  assign shortcut = (bus.divisor == '0) || (bus.dividend < bus.divisor);
`else
  assign shortcut = 1'b0;
`endif

  // The extra top bit of the subtract acts as the borrow flag.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign borrow  = diff[WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (shortcut) begin
            q_d    = (bus.divisor == '0) ? '1 : '0;
            r_d    = bus.dividend;
            dbz_d  = (bus.divisor == '0);
            done_d = 1'b1;
          end else begin
            dvd_d   = bus.dividend;
            dvs_d   = bus.divisor;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          q_d     = quo_d;
          r_d     = rem_d;
          dbz_d   = (dvs_q == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = done_q;
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_unsigned_divider.sv
// tb/tb_seq_unsigned_divider.sv - directed and random checks of seq_unsigned_divider at WIDTH 8 and 16
module tb_seq_unsigned_divider;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_unsigned_divider_if #(.WIDTH(8))  dif();
  seq_unsigned_divider_if #(.WIDTH(16)) dif16();

  seq_unsigned_divider #(.WIDTH(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(dif));
  seq_unsigned_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(dif16));

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic, with divide-by-zero giving all-ones / dividend.
  function automatic int exp_lat(input int w, input longint a, input longint b);
`ifdef DIV_SHORTCUT_EN
    if (b == 0 || a < b) return 0;
`endif
    return w;
  endfunction

  task automatic op8(input int a, input int b);
    int lat, bcnt;
    dif.dividend = 8'(a);
    dif.divisor  = 8'(b);
    dif.start    = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    lat = 0; bcnt = 0;
    while (!dif.done && lat < 40) begin
      if (dif.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("%0d/%0d latency", a, b), lat, exp_lat(8, a, b));
    check($sformatf("%0d/%0d busy cycles", a, b), bcnt, exp_lat(8, a, b));
    check($sformatf("%0d/%0d quotient", a, b), dif.quotient, (b == 0) ? 255 : a / b);
    check($sformatf("%0d/%0d remainder", a, b), dif.remainder, (b == 0) ? a : a % b);
    check($sformatf("%0d/%0d dbz", a, b), dif.div_by_zero, (b == 0) ? 1 : 0);
  endtask

  task automatic op16(input int a, input int b);
    int lat;
    dif16.dividend = 16'(a);
    dif16.divisor  = 16'(b);
    dif16.start    = 1'b1;
    @(posedge clk); #1;
    dif16.start = 1'b0;
    lat = 0;
    while (!dif16.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("w16 %0d/%0d latency", a, b), lat, exp_lat(16, a, b));
    check($sformatf("w16 %0d/%0d quotient", a, b), dif16.quotient, (b == 0) ? 65535 : a / b);
    check($sformatf("w16 %0d/%0d remainder", a, b), dif16.remainder, (b == 0) ? a : a % b);
    check($sformatf("w16 %0d/%0d dbz", a, b), dif16.div_by_zero, (b == 0) ? 1 : 0);
  endtask

  initial begin
    int lat, seen, a, b;
    rst_n = 1'b0;
    dif.start = 1'b0;   dif.dividend = '0;   dif.divisor = '0;
    dif16.start = 1'b0; dif16.dividend = '0; dif16.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", dif.busy, 0);
    check("reset done", dif.done, 0);
    check("reset quotient", dif.quotient, 0);
    check("reset remainder", dif.remainder, 0);
    check("reset dbz", dif.div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8(100, 7);
    @(posedge clk); #1;
    check("done single pulse", dif.done, 0);
    op8(200, 15);
    op8(255, 3);

    op8(37, 0);
    op8(10, 3);

    // Operand change plus start while busy must not disturb the running division.
    dif.dividend = 8'd100; dif.divisor = 8'd7; dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    dif.dividend = 8'd9; dif.divisor = 8'd9; dif.start = 1'b1;
    @(posedge clk); #1;
    lat++;
    dif.start = 1'b0;
    while (!dif.done && lat < 40) begin @(posedge clk); #1; lat++; end
    check("ignored start latency", lat, 8);
    check("ignored start quotient", dif.quotient, 14);
    check("ignored start remainder", dif.remainder, 2);
    op8(10, 3);   // started in the done cycle

    // Reset mid-division.
    dif.dividend = 8'd255; dif.divisor = 8'd3; dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort busy", dif.busy, 0);
    check("abort done", dif.done, 0);
    check("abort quotient", dif.quotient, 0);
    check("abort remainder", dif.remainder, 0);
    check("abort dbz", dif.div_by_zero, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (dif.done) seen++; end
    check("abort no done", seen, 0);
    op8(50, 5);

    op8(5, 9);
    op8(6, 0);
    op8(9, 5);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      op8(a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    op16(65535, 255);
    op16(1000, 0);
    for (int i = 0; i < 10; i++) begin
      op16($urandom_range(0, 65535), $urandom_range(0, 65535));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
